sprite_compositor: RTL and testbench

- Per-pixel compositor for the VGA path. Successor to the single-sprite map/pacman renderer.
- Overlays N_SPRITES square sprites with fixed priority onto the maze map.
- Double-buffers sprite positions per frame so moves never tear.
- Reports per-frame collisions of sprite 0 (pacman) against other sprites and against walls to game logic.

---
 rtl/sprite_compositor_pkg.sv | 28 ++
 rtl/sprite_compositor_hit.sv | 36 +++
 rtl/sprite_compositor.sv | 193 +++++++++++++++++++
 tb/tb_sprite_compositor.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/sprite_compositor_pkg.sv
// Shared constants and helpers for the sprite compositor: map window, colours,
// wall encoding and packed-slice extraction.
package sprite_compositor_pkg;

  localparam int MAP_LU_X = 150;
  localparam int MAP_LU_Y = 50;
  localparam int MAP_RD_X = 497;
  localparam int MAP_RD_Y = 455;
  localparam int SCR_W    = 640;
  localparam int SCR_H    = 480;

  localparam logic [7:0] COLOR_BG   = 8'b00000000;
  localparam logic [7:0] COLOR_WALL = 8'b11010000;

  localparam logic [1:0] MAP_WALL = 2'b00;

  localparam int SLICE_MAX = 16;
  localparam int VEC_MAX   = 128;

  // Extract slice k of width w from a zero-extended packed vector.
  function automatic logic [SLICE_MAX-1:0] getSlice(input logic [VEC_MAX-1:0] vec,
                                                    input int k, input int w);
    logic [SLICE_MAX-1:0] mask;
    mask = (SLICE_MAX'(1) << w) - SLICE_MAX'(1);
    return SLICE_MAX'(vec >> (k * w)) & mask;
  endfunction

endpackage

// File: rtl/sprite_compositor_hit.sv
// Combinational bounding-box test of one square sprite against the current pixel.
module sprite_hit #(
  parameter int COORD_W  = 11,
  parameter int POS_W    = 9,
  parameter int SPRITE_W = 24,
  parameter int MAP_LU_X = 150,
  parameter int MAP_LU_Y = 50
) (
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  input  logic [POS_W-1:0]   posX_i,
  input  logic [POS_W-1:0]   posY_i,
  input  logic               en_i,
  input  logic               inmap_i,
  output logic               hit_o
);

  localparam int EW = COORD_W + 1;
  localparam logic [EW-1:0] HALF = EW'(SPRITE_W / 2);

  logic [EW-1:0] px, py, loX, hiX, loY, hiY, cx, cy;

  assign px = EW'(MAP_LU_X) + EW'(posX_i);
  assign py = EW'(MAP_LU_Y) + EW'(posY_i);

  // A lower bound that would go negative clips to zero instead of wrapping.
  assign loX = (px >= HALF) ? px - HALF : '0;
  assign loY = (py >= HALF) ? py - HALF : '0;
  assign hiX = px + HALF;
  assign hiY = py + HALF;
  assign cx  = EW'(x_i);
  assign cy  = EW'(y_i);

  assign hit_o = en_i && inmap_i && (cx >= loX) && (cx < hiX) && (cy >= loY) && (cy < hiY);

endmodule

// File: rtl/sprite_compositor.sv
// Per-pixel compositor: overlays prioritised sprites on the maze map and reports
// per-frame collisions of sprite 0 against other sprites and walls.
module sprite_compositor
  import sprite_compositor_pkg::*;
#(
  parameter int N_SPRITES = 4,
  parameter int COORD_W   = 11,
  parameter int POS_W     = 9,
  parameter int SPRITE_W  = 24,
  parameter int RGB_W     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [COORD_W-1:0]         x,
  input  logic [COORD_W-1:0]         y,
  input  logic                       pix_valid,
  input  logic                       frame_start,
  input  logic [N_SPRITES*POS_W-1:0] spr_x,
  input  logic [N_SPRITES*POS_W-1:0] spr_y,
  input  logic [N_SPRITES-1:0]       spr_en,
  input  logic [N_SPRITES*RGB_W-1:0] spr_color,
  output logic [POS_W-1:0]           map_x,
  output logic [POS_W-1:0]           map_y,
  input  logic [1:0]                 map_pixel,
  output logic [RGB_W-1:0]           rgb,
  output logic                       rgb_valid,
  output logic [N_SPRITES-1:0]       coll_spr,
  output logic                       coll_wall,
  output logic                       coll_valid
);

  localparam logic [N_SPRITES-1:0] OTHER_MASK = ~N_SPRITES'(1);

  logic [N_SPRITES*POS_W-1:0] shX_q, shY_q;
  logic [N_SPRITES-1:0]       shEn_q;
  logic [N_SPRITES*RGB_W-1:0] shColor_q;

  logic [COORD_W-1:0] x0_q, y0_q;
  logic               v0_q, inmap0_q, onscr0_q;
  logic [POS_W-1:0]   mapX_q, mapY_q;
  logic               inmap_d, onscr_d;

  logic [N_SPRITES-1:0] hitVec, hit1_q;
  logic                 anyHit_d, anyHit1_q;
  logic [RGB_W-1:0]     color_d, color1_q;
  logic                 v1_q, inmap1_q, onscr1_q;

  logic                 wall;
  logic [RGB_W-1:0]     rgb_d, rgb_q;
  logic [N_SPRITES-1:0] accSpr_d, accSpr_q, collSpr_q;
  logic                 accWall_d, accWall_q, collWall_q, collValid_q;

  // Shadow copies of the sprite table; only these feed rendering and collisions.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shX_q     <= '0;
      shY_q     <= '0;
      shEn_q    <= '0;
      shColor_q <= '0;
    end else if (frame_start) begin
      shX_q     <= spr_x;
      shY_q     <= spr_y;
      shEn_q    <= spr_en;
      shColor_q <= spr_color;
    end
  end

  assign inmap_d = (x >= COORD_W'(MAP_LU_X)) && (x < COORD_W'(MAP_RD_X)) &&
                   (y >= COORD_W'(MAP_LU_Y)) && (y < COORD_W'(MAP_RD_Y));
  assign onscr_d = (x < COORD_W'(SCR_W)) && (y < COORD_W'(SCR_H));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x0_q     <= '0;
      y0_q     <= '0;
      v0_q     <= 1'b0;
      inmap0_q <= 1'b0;
      onscr0_q <= 1'b0;
      mapX_q   <= '0;
      mapY_q   <= '0;
    end else begin
      x0_q     <= x;
      y0_q     <= y;
      v0_q     <= pix_valid;
      inmap0_q <= inmap_d;
      onscr0_q <= onscr_d;
      mapX_q   <= POS_W'(x - COORD_W'(MAP_LU_X));
      mapY_q   <= POS_W'(y - COORD_W'(MAP_LU_Y));
    end
  end

  assign map_x = mapX_q;
  assign map_y = mapY_q;

  for (genvar k = 0; k < N_SPRITES; k++) begin : gHit
    sprite_hit #(
      .COORD_W (COORD_W),
      .POS_W   (POS_W),
      .SPRITE_W(SPRITE_W),
      .MAP_LU_X(MAP_LU_X),
      .MAP_LU_Y(MAP_LU_Y)
    ) uHit (
      .x_i    (x0_q),
      .y_i    (y0_q),
      .posX_i (shX_q[k*POS_W +: POS_W]),
      .posY_i (shY_q[k*POS_W +: POS_W]),
      .en_i   (shEn_q[k]),
      .inmap_i(inmap0_q),
      .hit_o  (hitVec[k])
    );
  end

  // Scan from lowest priority up so the lowest hitting index wins.
  always_comb begin
    anyHit_d = 1'b0;
    color_d  = '0;
    for (int k = N_SPRITES - 1; k >= 0; k--) begin
      if (hitVec[k]) begin
        anyHit_d = 1'b1;
        color_d  = RGB_W'(getSlice(VEC_MAX'(shColor_q), k, RGB_W));
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit1_q    <= '0;
      anyHit1_q <= 1'b0;
      color1_q  <= '0;
      v1_q      <= 1'b0;
      inmap1_q  <= 1'b0;
      onscr1_q  <= 1'b0;
    end else begin
      hit1_q    <= hitVec;
      anyHit1_q <= anyHit_d;
      color1_q  <= color_d;
      v1_q      <= v0_q;
      inmap1_q  <= inmap0_q;
      onscr1_q  <= onscr0_q;
    end
  end

  // Map ROM data arrives aligned with the stage-1 registers.
  assign wall = inmap1_q && (map_pixel == MAP_WALL);

  always_comb begin
    rgb_d = rgb_q;
    if (v1_q) begin
      if (!(onscr1_q && inmap1_q)) rgb_d = RGB_W'(COLOR_BG);
      else if (anyHit1_q)          rgb_d = color1_q;
      else if (wall)               rgb_d = RGB_W'(COLOR_WALL);
      else                         rgb_d = RGB_W'(COLOR_BG);
    end
  end

  assign rgb       = rgb_d;
  assign rgb_valid = v1_q;

  // At a frame boundary the old totals are flushed and the current pixel seeds the new ones.
  always_comb begin
    accSpr_d  = frame_start ? '0 : accSpr_q;
    accWall_d = frame_start ? 1'b0 : accWall_q;
    if (v1_q && hit1_q[0]) begin
      accSpr_d  = accSpr_d | (hit1_q & OTHER_MASK);
      accWall_d = accWall_d | wall;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rgb_q       <= RGB_W'(COLOR_BG);
      accSpr_q    <= '0;
      accWall_q   <= 1'b0;
      collSpr_q   <= '0;
      collWall_q  <= 1'b0;
      collValid_q <= 1'b0;
    end else begin
      rgb_q       <= rgb_d;
      accSpr_q    <= accSpr_d;
      accWall_q   <= accWall_d;
      collValid_q <= frame_start;
      if (frame_start) begin
        collSpr_q  <= accSpr_q;
        collWall_q <= accWall_q;
      end
    end
  end

  assign coll_spr   = collSpr_q;
  assign coll_wall  = collWall_q;
  assign coll_valid = collValid_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor with a synchronous map ROM model.
module tb_sprite_compositor;

  localparam int N  = 4;
  localparam int CW = 11;
  localparam int PW = 9;
  localparam int RW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [CW-1:0]   x, y;
  logic            pix_valid, frame_start;
  logic [N*PW-1:0] spr_x, spr_y;
  logic [N-1:0]    spr_en;
  logic [N*RW-1:0] spr_color;
  logic [PW-1:0]   map_x, map_y;
  logic [1:0]      map_pixel;
  logic [RW-1:0]   rgb;
  logic            rgb_valid;
  logic [N-1:0]    coll_spr;
  logic            coll_wall, coll_valid;

  int checkCount = 0;
  int errorCount = 0;

  sprite_compositor dut (
    .clk        (clk),
    .reset      (reset),
    .x          (x),
    .y          (y),
    .pix_valid  (pix_valid),
    .frame_start(frame_start),
    .spr_x      (spr_x),
    .spr_y      (spr_y),
    .spr_en     (spr_en),
    .spr_color  (spr_color),
    .map_x      (map_x),
    .map_y      (map_y),
    .map_pixel  (map_pixel),
    .rgb        (rgb),
    .rgb_valid  (rgb_valid),
    .coll_spr   (coll_spr),
    .coll_wall  (coll_wall),
    .coll_valid (coll_valid)
  );

  // Map: 20-pixel wall border plus a small wall block at map (90..95, 90..95).
  function automatic logic [1:0] romData(input logic [PW-1:0] mx, input logic [PW-1:0] my);
    if (mx < 20 || my < 20 || (mx >= 90 && mx < 96 && my >= 90 && my < 96)) return 2'b00;
    return 2'b01;
  endfunction

  always_ff @(posedge clk) map_pixel <= romData(map_x, map_y);

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic setSprite(input int k, input int sx, input int sy, input logic [7:0] col);
    spr_x[k*PW +: PW]     = PW'(sx);
    spr_y[k*PW +: PW]     = PW'(sy);
    spr_color[k*RW +: RW] = col;
  endtask

  // Issue one pixel and return rgb/rgb_valid two cycles later plus rgb_valid one cycle later.
  task automatic applyStimulus(input int px, input int py, output logic [7:0] rgbOut,
                               output logic validOut, output logic earlyValid);
    @(negedge clk);
    x = CW'(px);
    y = CW'(py);
    pix_valid = 1'b1;
    @(negedge clk);
    pix_valid = 1'b0;
    earlyValid = rgb_valid;
    @(negedge clk);
    rgbOut   = rgb;
    validOut = rgb_valid;
  endtask

  task automatic pixelCheck(input string tag, input int px, input int py, input logic [7:0] expected);
    logic [7:0] r;
    logic v, e;
    applyStimulus(px, py, r, v, e);
    checkOutput(tag, 32'(r), 32'(expected));
  endtask

  task automatic frameStart(output logic cValid, output logic [N-1:0] cSpr,
                            output logic cWall, output logic cValidAfter);
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    cValid = coll_valid;
    cSpr   = coll_spr;
    cWall  = coll_wall;
    @(negedge clk);
    cValidAfter = coll_valid;
  endtask

  logic [7:0]   r;
  logic         v, e, cv, cw, cva;
  logic [N-1:0] cs;

  initial begin
    reset = 1'b0;
    frame_start = 1'b0;
    pix_valid = 1'b0;
    x = '0;
    y = '0;
    spr_x = '0;
    spr_y = '0;
    spr_en = '0;
    spr_color = '0;

    repeat (2) @(negedge clk);
    x = CW'(250);
    y = CW'(150);
    pix_valid = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_rgb", 32'(rgb), 32'h00);
    checkOutput("reset_rgb_valid", 32'(rgb_valid), 32'h0);
    checkOutput("reset_coll_spr", 32'(coll_spr), 32'h0);
    checkOutput("reset_coll_wall", 32'(coll_wall), 32'h0);
    checkOutput("reset_coll_valid", 32'(coll_valid), 32'h0);
    pix_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    setSprite(0, 100, 100, 8'h3F);
    setSprite(1, 100, 100, 8'hE0);
    spr_en = 4'b0011;
    pixelCheck("no_shadow_floor", 250, 150, 8'h00);
    pixelCheck("no_shadow_wall", 160, 60, 8'hD0);

    frameStart(cv, cs, cw, cva);
    applyStimulus(250, 150, r, v, e);
    checkOutput("prio_rgb", 32'(r), 32'h3F);
    checkOutput("latency_valid_2", 32'(v), 32'h1);
    checkOutput("latency_valid_1", 32'(e), 32'h0);
    @(negedge clk);
    checkOutput("valid_drops", 32'(rgb_valid), 32'h0);
    checkOutput("rgb_holds", 32'(rgb), 32'h3F);

    spr_en = 4'b0010;
    frameStart(cv, cs, cw, cva);
    pixelCheck("prio_sprite1", 250, 150, 8'hE0);

    spr_en = 4'b0001;
    frameStart(cv, cs, cw, cva);
    pixelCheck("edge_left", 238, 150, 8'h3F);
    pixelCheck("edge_right_out", 262, 150, 8'h00);
    pixelCheck("edge_right_in", 261, 150, 8'h3F);
    pixelCheck("edge_top", 250, 138, 8'h3F);
    pixelCheck("edge_bottom_out", 250, 162, 8'h00);
    pixelCheck("wall_block_no_sprite", 242, 142, 8'h3F);

    setSprite(0, 5, 5, 8'h3F);
    frameStart(cv, cs, cw, cva);
    pixelCheck("clip_origin", 150, 50, 8'h3F);
    pixelCheck("clip_offmap", 149, 50, 8'h00);
    pixelCheck("clip_no_wrap", 480, 60, 8'hD0);

    setSprite(0, 100, 100, 8'h3F);
    frameStart(cv, cs, cw, cva);
    setSprite(0, 200, 100, 8'h3F);
    pixelCheck("tear_old_pos", 250, 150, 8'h3F);
    pixelCheck("tear_new_pos_hidden", 350, 150, 8'h00);
    frameStart(cv, cs, cw, cva);
    pixelCheck("tear_new_pos", 350, 150, 8'h3F);
    pixelCheck("tear_old_pos_gone", 250, 150, 8'h00);

    setSprite(0, 100, 100, 8'h3F);
    setSprite(2, 110, 100, 8'h1C);
    spr_en = 4'b0101;
    frameStart(cv, cs, cw, cva);
    pixelCheck("coll_overlap_rgb", 250, 150, 8'h3F);
    pixelCheck("coll_wall_rgb", 242, 142, 8'h3F);
    pixelCheck("coll_spr2_rgb", 265, 150, 8'h1C);
    frameStart(cv, cs, cw, cva);
    checkOutput("coll_valid_pulse", 32'(cv), 32'h1);
    checkOutput("coll_spr_hit", 32'(cs), 32'h4);
    checkOutput("coll_wall_hit", 32'(cw), 32'h1);
    checkOutput("coll_valid_once", 32'(cva), 32'h0);

    pixelCheck("quiet_frame_rgb", 400, 300, 8'h00);
    frameStart(cv, cs, cw, cva);
    checkOutput("quiet_valid", 32'(cv), 32'h1);
    checkOutput("quiet_coll_spr", 32'(cs), 32'h0);
    checkOutput("quiet_coll_wall", 32'(cw), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
